// File: rtl/sa_fifo_pkg.sv
// rtl/sa_fifo_pkg.sv - shared constants for the systolic-array FIFO controller
package sa_fifo_pkg;

    localparam int SA_FIFO_DW               = 128;
    localparam int SA_FIFO_AW               = 7;
    localparam int SA_FIFO_DEPTH            = 128;
    localparam int SA_FIFO_AFULL_TH_DEFAULT = 120;

endpackage

// File: rtl/sa_fifo_ctrl_128x128_if.sv
// rtl/sa_fifo_ctrl_128x128_if.sv - write/read valid-ready handshake bundle
interface sa_fifo_ctrl_128x128_if;
    import sa_fifo_pkg::*;

    logic                  wr_pvld;
    logic                  wr_prdy;
    logic [SA_FIFO_DW-1:0] wr_pd;
    logic                  rd_pvld;
    logic                  rd_prdy;
    logic [SA_FIFO_DW-1:0] rd_pd;

    // Producer/consumer side
    modport master (
        output wr_pvld, wr_pd, rd_prdy,
        input  wr_prdy, rd_pvld, rd_pd
    );

    // FIFO side
    modport slave (
        input  wr_pvld, wr_pd, rd_prdy,
        output wr_prdy, rd_pvld, rd_pd
    );
endinterface

// File: rtl/sa_fifo_ctrl_128x128_ram.sv
// rtl/sa_fifo_ctrl_128x128_ram.sv - 128x128 one-write one-read RAM model, dout held between reads
module sa_ram_rws_128x128 (
    input  logic         clk,
    input  logic [6:0]   ra,
    input  logic         re,
    output logic [127:0] dout,
    input  logic [6:0]   wa,
    input  logic         we,
    input  logic [127:0] di,
    input  logic [31:0]  pwrbus_ram_pd
);
    logic [127:0] mem [0:127];
    logic [127:0] dout_d;
    logic [127:0] dout_q;
    logic         unused_pwrbus;

    // Power-control bus only matters for the real macro
    assign unused_pwrbus = ^pwrbus_ram_pd;

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= di;
    end

    // Read data updates only on re, otherwise holds the last fetched word
    always_comb begin
        dout_d = dout_q;
        if (re) dout_d = mem[ra];
    end

    // Read data register
    always_ff @(posedge clk) begin
        dout_q <= dout_d;
    end

    assign dout = dout_q;
endmodule

// File: rtl/sa_fifo_ctrl_128x128.sv
// rtl/sa_fifo_ctrl_128x128.sv - valid/ready FIFO controller with RAM prefetch
module sa_fifo_ctrl_128x128
    import sa_fifo_pkg::*;
#(
    parameter int DW       = SA_FIFO_DW,
    parameter int AW       = SA_FIFO_AW,
    parameter int AFULL_TH = SA_FIFO_AFULL_TH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    sa_fifo_ctrl_128x128_if.slave  io,
    input  logic                   flush,
    output logic [AW:0]            fifo_cnt,
    output logic                   wr_afull,
    output logic                   fifo_empty,
    input  logic [31:0]            pwrbus_ram_pd
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(1 << AW);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);

    logic [AW-1:0] wr_ptr_d,  wr_ptr_q;
    logic [AW-1:0] rd_ptr_d,  rd_ptr_q;
    logic [AW:0]   ram_cnt_d, ram_cnt_q;
    logic          out_vld_d, out_vld_q;
    logic          push, pop, re;
    logic [DW-1:0] ram_dout;

    // Occupancy counts both RAM-resident entries and the head sitting on dout
    assign fifo_cnt   = ram_cnt_q + (AW+1)'(out_vld_q);
    assign fifo_empty = (fifo_cnt == '0);
    assign wr_afull   = (fifo_cnt >= AFULL_C);
    // Ready comes from registered state only, so a pop at full never admits a push that cycle
    assign io.wr_prdy = ~rst & (fifo_cnt != DEPTH_C);
    assign io.rd_pvld = out_vld_q;
    assign io.rd_pd   = ram_dout;

    assign push = io.wr_pvld & io.wr_prdy & ~flush;
    assign pop  = out_vld_q & io.rd_prdy;
    // Prefetch whenever the output slot is free or being vacated this cycle
    assign re   = (ram_cnt_q != '0) & (~out_vld_q | pop) & ~flush;

    // Next-state for pointers, stored count and head-valid; flush wins over everything
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        out_vld_d = out_vld_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ram_cnt_d = '0;
            out_vld_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (re)   rd_ptr_d = rd_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(re);
            if (re)       out_vld_d = 1'b1;
            else if (pop) out_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    sa_ram_rws_128x128 u_ram (
        .clk           (clk),
        .ra            (rd_ptr_q),
        .re            (re),
        .dout          (ram_dout),
        .wa            (wr_ptr_q),
        .we            (push),
        .di            (io.wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (ram_cnt_q <= DEPTH_C) && (fifo_cnt <= DEPTH_C));
endmodule

// File: tb/tb_sa_fifo_ctrl_128x128.sv
// tb/tb_sa_fifo_ctrl_128x128.sv - self-checking bench for sa_fifo_ctrl_128x128
module tb_sa_fifo_ctrl_128x128;
    logic         clk;
    logic         rst;
    logic         flush;
    logic [7:0]   fifo_cnt;
    logic         wr_afull;
    logic         fifo_empty;
    logic [31:0]  pwrbus_ram_pd;

    int n_cmp;
    int n_err;

    sa_fifo_ctrl_128x128_if bus ();

    sa_fifo_ctrl_128x128 dut (
        .clk           (clk),
        .rst           (rst),
        .io            (bus),
        .flush         (flush),
        .fifo_cnt      (fifo_cnt),
        .wr_afull      (wr_afull),
        .fifo_empty    (fifo_empty),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wv;
        logic [127:0] wd;
        logic         rr;
        logic         fl;
        logic         e_vld;
        logic [7:0]   e_cnt;
        logic         e_empty;
        logic         e_prdy;
        logic         e_afull;
        logic         chk_pd;
        logic [127:0] e_pd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [127:0] wd, input logic rr, input logic fl);
        bus.wr_pvld = wv;
        bus.wr_pd   = wd;
        bus.rd_prdy = rr;
        flush       = fl;
    endtask

    // Each row: check outputs at this negedge, then apply the row's inputs for the next edge
    task automatic run_table();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_rd_pvld", i), 128'(bus.rd_pvld), 128'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_fifo_cnt", i), 128'(fifo_cnt), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_fifo_empty", i), 128'(fifo_empty), 128'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_wr_prdy", i), 128'(bus.wr_prdy), 128'(tbl[i].e_prdy));
            chk($sformatf("tbl%0d_wr_afull", i), 128'(wr_afull), 128'(tbl[i].e_afull));
            if (tbl[i].chk_pd) chk($sformatf("tbl%0d_rd_pd", i), bus.rd_pd, tbl[i].e_pd);
            drive(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl);
        end
    endtask

    initial begin
        logic [127:0] w0, w1, w2, w3, wx, d;
        logic [127:0] q [$];
        int sent, rcvd, w;
        logic found;

        n_cmp = 0;
        n_err = 0;
        w0 = {16{8'hA5}};
        w1 = {4{32'h1111_2222}};
        w2 = {4{32'h3333_4444}};
        w3 = {4{32'h5555_6666}};
        wx = {4{32'hCAFE_F00D}};

        //           wv  wd   rr  fl  vld cnt     emp prdy af  pd? e_pd
        tbl[0] = '{1'b1, w0,  1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
        tbl[1] = '{1'b0, '0,  1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, '0};
        tbl[2] = '{1'b0, '0,  1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, w0};
        tbl[3] = '{1'b1, w1,  1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
        tbl[4] = '{1'b1, w2,  1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, '0};
        tbl[5] = '{1'b1, w3,  1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, w1};
        tbl[6] = '{1'b0, '0,  1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, w1};
        tbl[7] = '{1'b0, '0,  1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, w2};
        tbl[8] = '{1'b0, '0,  1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, w3};
        tbl[9] = '{1'b0, '0,  1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0};

        pwrbus_ram_pd = 32'h0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_prdy", 128'(bus.wr_prdy), 128'(0));
        chk("rst_rd_pvld", 128'(bus.rd_pvld), 128'(0));
        chk("rst_fifo_cnt", 128'(fifo_cnt), 128'(0));
        chk("rst_fifo_empty", 128'(fifo_empty), 128'(1));
        chk("rst_wr_afull", 128'(wr_afull), 128'(0));
        rst = 1'b0;

        // Single-word fall-through latency and short bursts
        run_table();

        // Fill to full, watching the almost-full threshold
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk($sformatf("fill%0d_cnt", i), 128'(fifo_cnt), 128'(i));
            chk($sformatf("fill%0d_prdy", i), 128'(bus.wr_prdy), 128'(1));
            chk($sformatf("fill%0d_afull", i), 128'(wr_afull), 128'(i >= 120));
            drive(1'b1, 128'(i), 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("full_cnt", 128'(fifo_cnt), 128'(128));
        chk("full_prdy", 128'(bus.wr_prdy), 128'(0));
        chk("full_afull", 128'(wr_afull), 128'(1));

        // Stall at full while the producer keeps pushing
        drive(1'b1, {4{32'hDEAD_BEEF}}, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_rd_pd", k), bus.rd_pd, 128'(0));
            chk($sformatf("hold%0d_cnt", k), 128'(fifo_cnt), 128'(128));
            chk($sformatf("hold%0d_prdy", k), 128'(bus.wr_prdy), 128'(0));
        end
        // Drain one per cycle
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("drain%0d_vld", i), 128'(bus.rd_pvld), 128'(1));
            chk($sformatf("drain%0d_rd_pd", i), bus.rd_pd, 128'(i));
            drive(1'b0, '0, 1'b1, 1'b0);
            @(negedge clk);
        end
        chk("drained_cnt", 128'(fifo_cnt), 128'(0));
        chk("drained_empty", 128'(fifo_empty), 128'(1));
        chk("drained_vld", 128'(bus.rd_pvld), 128'(0));
        drive(1'b0, '0, 1'b0, 1'b0);

        // Random stream against a queue model
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 4000 && rcvd < 300; cyc++) begin
            logic wv, rr;
            @(negedge clk);
            chk("rnd_cnt", 128'(fifo_cnt), 128'(q.size()));
            chk("rnd_prdy", 128'(bus.wr_prdy), 128'(q.size() != 128));
            if (bus.rd_pvld) begin
                if (q.size() == 0) chk("rnd_vld_when_empty", 128'(1), 128'(0));
                else chk($sformatf("rnd_data%0d", rcvd), bus.rd_pd, q[0]);
            end
            wv = (sent < 300) && ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 1) == 1);
            d  = {$urandom, $urandom, $urandom, $urandom};
            drive(wv, d, rr, 1'b0);
            if (rr && bus.rd_pvld && q.size() > 0) begin
                void'(q.pop_front());
                rcvd++;
            end
            if (wv && (q.size() + (rr && bus.rd_pvld ? 1 : 0)) != 128) begin
                q.push_back(d);
                sent++;
            end
        end
        chk("rnd_received", 128'(rcvd), 128'(300));
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        q.delete();

        // Flush with simultaneous push and pop
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 128'(100 + i), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("preflush_cnt", 128'(fifo_cnt), 128'(10));
        drive(1'b1, {4{32'hBAD0_BAD0}}, 1'b1, 1'b1);
        @(negedge clk);
        chk("flush_cnt", 128'(fifo_cnt), 128'(0));
        chk("flush_vld", 128'(bus.rd_pvld), 128'(0));
        chk("flush_empty", 128'(fifo_empty), 128'(1));
        drive(1'b1, wx, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        found = 1'b0;
        for (w = 0; w < 8; w++) begin
            if (bus.rd_pvld) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("postflush_found", 128'(found), 128'(1));
        chk("postflush_rd_pd", bus.rd_pd, wx);
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("postflush_empty", 128'(fifo_empty), 128'(1));
        drive(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 128'(200 + i), 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("prerst_vld", 128'(bus.rd_pvld), 128'(1));
        chk("prerst_cnt", 128'(fifo_cnt), 128'(3));
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 128'(bus.rd_pvld), 128'(0));
        chk("arst_prdy", 128'(bus.wr_prdy), 128'(0));
        chk("arst_cnt", 128'(fifo_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
